// File: rtl/dm_responder.sv
// dm_responder: single-outstanding data-memory responder with wait states and byte/half/word access.
// Optional store logging is enabled by defining DM_WRITE_LOG_EN.
module dm_responder #(
    parameter int unsigned DEPTH_WORDS = 3072,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wd,
    input  logic [1:0]  req_op,
    input  logic        req_sext,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rd,
    output logic        resp_err
);
    localparam int unsigned IW = $clog2(DEPTH_WORDS);
    localparam logic [31:0] LIMIT = 32'(4 * DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, sext_q, err_q, err_d;
    logic [1:0]  op_q;
    logic [31:0] addr_q, wd_q, rd_q, rd_d;
    logic [31:0] mem_q [DEPTH_WORDS];

    logic        accept, enter, err, a_we, a_sext;
    logic [1:0]  a_op;
    logic [31:0] a_addr, a_wd, word, ld, merged, wlanes;
    logic [15:0] sh;
    logic [3:0]  mask;
    logic [IW-1:0] idx;

    assign req_ready  = state_q == IDLE;
    assign resp_valid = state_q == RESP;
    assign resp_rd    = rd_q;
    assign resp_err   = err_q;
    assign accept     = req_valid && req_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: if (req_valid) begin
                state_d = WAIT_CYCLES == 0 ? RESP : WAIT;
                cnt_d   = 4'(WAIT_CYCLES);
            end
            WAIT: if (cnt_q == 4'd0) state_d = RESP;
                  else cnt_d = cnt_q - 4'd1;
            RESP: if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // With zero wait states the access happens on the accept edge, so use live inputs in IDLE.
    assign a_we   = state_q == IDLE ? req_we   : we_q;
    assign a_addr = state_q == IDLE ? req_addr : addr_q;
    assign a_wd   = state_q == IDLE ? req_wd   : wd_q;
    assign a_op   = state_q == IDLE ? req_op   : op_q;
    assign a_sext = state_q == IDLE ? req_sext : sext_q;
    assign enter  = state_d == RESP && state_q != RESP;

    assign err = a_op == 2'b11 || (a_op == 2'b01 && a_addr[0]) ||
                 (a_op == 2'b00 && a_addr[1:0] != 2'b00) || a_addr >= LIMIT;
    assign idx  = a_addr[IW+1:2];
    assign word = mem_q[idx];
    assign sh   = 16'(word >> {a_addr[1:0], 3'b000});
    assign ld   = a_op == 2'b10 ? {{24{a_sext & sh[7]}}, sh[7:0]} :
                  a_op == 2'b01 ? {{16{a_sext & sh[15]}}, sh[15:0]} : word;
    assign mask = a_op == 2'b10 ? 4'b0001 << a_addr[1:0] :
                  a_op == 2'b01 ? (a_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wlanes = a_op == 2'b10 ? {4{a_wd[7:0]}} : a_op == 2'b01 ? {2{a_wd[15:0]}} : a_wd;
    assign rd_d  = err || a_we ? 32'd0 : ld;
    assign err_d = err;

    for (genvar g = 0; g < 4; g++) begin : g_lane
        assign merged[8*g +: 8] = mask[g] ? wlanes[8*g +: 8] : word[8*g +: 8];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wd_q    <= 32'd0;
            op_q    <= 2'b00;
            sext_q  <= 1'b0;
            rd_q    <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q   <= req_we;
                addr_q <= req_addr;
                wd_q   <= req_wd;
                op_q   <= req_op;
                sext_q <= req_sext;
            end
            if (enter) begin
                rd_q  <= rd_d;
                err_q <= err_d;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH_WORDS); i++) mem_q[i] <= 32'd0;
        end else if (enter && a_we && !err) begin
            mem_q[idx] <= merged;
        end
    end

`ifdef DM_WRITE_LOG_EN
    logic [31:0] pc_q, a_pc;
    assign a_pc = state_q == IDLE ? req_pc : pc_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pc_q <= 32'd0;
        else if (accept) pc_q <= req_pc;
    end

    always_ff @(posedge clk) begin
        if (reset && enter && a_we && !err)
            $display("@%08h: *%08h <= %08h", a_pc, {a_addr[31:2], 2'b00}, merged);
    end
`else
    logic unused_pc;
    assign unused_pc = ^req_pc;
`endif
endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: directed scoreboard bench for dm_responder with a byte-level memory model.
module tb_dm_responder;
    localparam int WAIT_CYCLES = 2;

    logic        clk = 1'b0, reset = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, req_sext = 1'b0, resp_ready = 1'b0;
    logic [31:0] req_addr = '0, req_wd = '0, req_pc = '0;
    logic [1:0]  req_op = 2'b00;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rd;

    int errors = 0, checks = 0;
    logic [32:0] sb_q[$];
    logic [7:0]  mb [12288];

    dm_responder #(.DEPTH_WORDS(3072), .WAIT_CYCLES(WAIT_CYCLES)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wd(req_wd), .req_op(req_op),
        .req_sext(req_sext), .req_pc(req_pc),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rd(resp_rd), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 12288; i++) mb[i] = 8'h00;
    endtask

    // Returns {err, rd} and applies committed stores to the byte model.
    task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [1:0] op, input logic sext, output logic [32:0] r);
        int n;
        logic [31:0] v;
        if (op == 2'b11 || (op == 2'b01 && addr[0]) || (op == 2'b00 && addr[1:0] != 2'b00) ||
            addr >= 32'h3000) begin
            r = {1'b1, 32'd0};
            return;
        end
        n = op == 2'b00 ? 4 : op == 2'b01 ? 2 : 1;
        v = 32'd0;
        for (int k = 0; k < n; k++) begin
            if (we) mb[addr + k] = wd[8*k +: 8];
            else v[8*k +: 8] = mb[addr + k];
        end
        if (!we && sext && op == 2'b10 && v[7]) v = v | 32'hFFFF_FF00;
        if (!we && sext && op == 2'b01 && v[15]) v = v | 32'hFFFF_0000;
        r = {1'b0, we ? 32'd0 : v};
    endtask

    // Called #1 after a rising edge with the DUT idle.
    task automatic xfer(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [1:0] op, input logic sext, input int hold);
        logic [32:0] e;
        int k;
        chk({tag, ".ready"}, req_ready, 1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wd = wd; req_op = op;
        req_sext = sext; req_pc = 32'h8000_0000 | addr;
        model(we, addr, wd, op, sext, e);
        sb_q.push_back(e);
        @(posedge clk);
        #1 req_valid = 1'b0;
        k = 0;
        do begin
            @(posedge clk);
            #1 k++;
        end while (!resp_valid && k < 20);
        chk({tag, ".valid"}, resp_valid, 1);
        chk({tag, ".latency"}, k, 1 + WAIT_CYCLES);
        e = sb_q.pop_front();
        chk({tag, ".rd"}, resp_rd, e[31:0]);
        chk({tag, ".err"}, resp_err, e[32]);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            chk({tag, ".hold_valid"}, resp_valid, 1);
            chk({tag, ".hold_rd"}, resp_rd, e[31:0]);
            chk({tag, ".hold_ready"}, req_ready, 0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        chk({tag, ".done_valid"}, resp_valid, 0);
        chk({tag, ".done_idle"}, req_ready, 1);
    endtask

    initial begin
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk("rst.valid", resp_valid, 0);
        chk("rst.rd", resp_rd, 0);
        chk("rst.err", resp_err, 0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1 chk("rst.ready", req_ready, 1);

        xfer("sw100", 1, 32'h100, 32'h1234_5678, 2'b00, 0, 0);
        xfer("lw100", 0, 32'h100, 32'h0, 2'b00, 1, 0);
        xfer("sb101", 1, 32'h101, 32'hFFFF_FFAB, 2'b10, 0, 0);
        xfer("lw100b", 0, 32'h100, 32'h0, 2'b00, 0, 0);
        xfer("lb101s", 0, 32'h101, 32'h0, 2'b10, 1, 0);
        xfer("lb101u", 0, 32'h101, 32'h0, 2'b10, 0, 0);
        xfer("sh102", 1, 32'h102, 32'h0000_BEEF, 2'b01, 0, 0);
        xfer("lh102s", 0, 32'h102, 32'h0, 2'b01, 1, 0);
        xfer("lh100u", 0, 32'h100, 32'h0, 2'b01, 0, 0);
        xfer("lh103", 0, 32'h103, 32'h0, 2'b01, 1, 0);
        xfer("sw3000", 1, 32'h3000, 32'hDEAD_BEEF, 2'b00, 0, 0);
        xfer("lw100c", 0, 32'h100, 32'h0, 2'b00, 0, 0);
        xfer("sw2ffc", 1, 32'h2FFC, 32'hCAFE_F00D, 2'b00, 0, 0);
        xfer("sb2fff", 1, 32'h2FFF, 32'h0000_0081, 2'b10, 0, 0);
        xfer("lw2ffc", 0, 32'h2FFC, 32'h0, 2'b00, 0, 0);
        xfer("lb2fff", 0, 32'h2FFF, 32'h0, 2'b10, 1, 0);
        xfer("op11", 0, 32'h100, 32'h0, 2'b11, 0, 0);
        xfer("sw102", 1, 32'h102, 32'h1111_1111, 2'b00, 0, 0);
        xfer("lw100d", 0, 32'h100, 32'h0, 2'b00, 0, 0);
        xfer("hold", 0, 32'h100, 32'h0, 2'b00, 0, 5);

        // Store abandoned by reset while waiting.
        chk("rs.ready", req_ready, 1);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h200; req_wd = 32'h5555_AAAA;
        req_op = 2'b00; req_sext = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("rs.valid", resp_valid, 0);
        chk("rs.rd", resp_rd, 0);
        chk("rs.err", resp_err, 0);
        chk("rs.ready_idle", req_ready, 1);
        repeat (3) @(posedge clk);
        #1 chk("rs.valid_held", resp_valid, 0);
        @(negedge clk) reset = 1'b1;
        model_clear();
        sb_q.delete();
        @(posedge clk);
        #1;
        xfer("lw200", 0, 32'h200, 32'h0, 2'b00, 0, 0);
        xfer("lw100z", 0, 32'h100, 32'h0, 2'b00, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dm_responder.md
DM_RESPONDER -- requirements
Module: dm_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 3072, meaning 32-bit words of storage (byte range 0x0000-0x2FFF).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, range 0-15, meaning wait states between accept and response.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports for the request channel:
- req_valid  input  1  request present
- req_ready  output  1  responder can accept
- req_we  input  1  1=store, 0=load
- req_addr  input  32  byte address
- req_wd  input  32  store data, right-aligned
- req_op  input  2  size: 00 word, 01 half, 10 byte, 11 illegal
- req_sext  input  1  load sign-extend (1) or zero-extend (0)
- req_pc  input  32  issuing instruction PC, used only for logging
REQ-006 SHALL have ports for the response channel:
- resp_valid  output  1  response present
- resp_ready  input  1  requester accepts response
- resp_rd  output  32  load result
- resp_err  output  1  request faulted

Function
REQ-007 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; req_ready=1 only in IDLE; resp_valid=1 only in RESP.
REQ-008 SHALL latch we/addr/wd/op/sext/pc on the edge where req_valid&&req_ready (accept edge A).
REQ-009 SHALL load a wait counter with WAIT_CYCLES at A, decrement it each cycle in WAIT, and enter RESP when it reaches 0; for WAIT_CYCLES=0, SHALL go IDLE->RESP directly.
REQ-010 SHALL perform the memory access on the edge entering RESP, so resp_valid rises at edge A+1+WAIT_CYCLES.
REQ-011 SHALL hold resp_rd and resp_err stable while resp_valid&&!resp_ready, and SHALL return to IDLE on the edge where resp_ready=1.
REQ-012 SHALL accept the next request no earlier than the cycle after the response handshake; at most one request is outstanding.
REQ-013 SHALL flag an error if op=11, if the half access has addr[0]=1, if the word access has addr[1:0]!=0, or if addr>=4*DEPTH_WORDS.
REQ-014 On error, SHALL set resp_err=1 and resp_rd=0, and SHALL leave memory unmodified.
REQ-015 Store SHALL write only the addressed bytes: byte lane addr[1:0], half lanes addr[1]*2..+1, word all lanes; other bytes SHALL be preserved.
REQ-016 Store response SHALL set resp_rd=0 and resp_err=0.
REQ-017 Load SHALL select the byte by addr[1:0] or the half by addr[1], then extend to 32 bits per req_sext; a word load ignores sext.
REQ-018 SHALL index memory by word address addr[31:2] (in-range only).

Reset
REQ-019 While reset=0, SHALL force state=IDLE, req_ready=1 after release, resp_valid=0, resp_rd=0, resp_err=0, wait counter=0, all memory words=0.
REQ-020 Reset asserted during WAIT SHALL abandon the request with no memory write; reset during RESP SHALL drop the response.

Configuration
REQ-021 With DM_WRITE_LOG_EN defined, each committed (non-error) store SHALL print "@<pc>: *<word byte-address> <= <merged 32-bit word>" (all 8-digit hex) on its commit edge.
REQ-022 Without DM_WRITE_LOG_EN, SHALL print nothing; req_pc SHALL remain a port and be ignored.

Verification
REQ-023 Store word 0x12345678 @0x100, WAIT_CYCLES=2 -> resp_valid at A+3, resp_err=0; word load @0x100 -> 0x12345678.
REQ-024 With 0x12345678 @0x100: store byte 0xAB @0x101 -> word 0x1234AB78; load byte @0x101 with sext=1 -> 0xFFFFFFAB, with sext=0 -> 0x000000AB.
REQ-025 Half load @0x103 -> resp_err=1, resp_rd=0; word store @0x3000 -> resp_err=1 and memory unchanged.
REQ-026 Hold resp_ready=0 for 5 cycles in RESP -> resp_valid, resp_rd stable and req_ready=0; resp_ready=1 -> IDLE next edge.
REQ-027 Assert reset one cycle after accepting a store @0x200 -> outputs reset, later load @0x200 returns 0; with DM_WRITE_LOG_EN, no log line printed.
